addsub_pipe: RTL and testbench
==============================

ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16: signed two's-complement lane width in bits.
REQ-002 Parameter LANES, default 4: number of independent parallel lanes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  input beat present.
REQ-006 o_ready  output  1  block can accept an input beat this cycle.
REQ-007 i_a  input  LANES*WIDTH  operand A; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-008 i_b  input  LANES*WIDTH  operand B, same packing as i_a.
REQ-009 i_mode  input  2  operation: 00 SUB (a-b), 01 ADD (a+b), 10 ACC_ADD (acc+a+b), 11 ACC_SUB (acc+a-b).
REQ-010 i_last  input  1  final beat of an accumulation sequence; ignored in SUB/ADD.
REQ-011 o_valid  output  1  result beat present on o.
REQ-012 i_ready  input  1  downstream accepts the result beat.
REQ-013 o  output  LANES*WIDTH  result, same packing as i_a.
REQ-014 o_ovf  output  LANES  per-lane overflow flag, aligned with o.

Function
REQ-015 An input beat SHALL be accepted when i_valid && o_ready; an output beat SHALL be consumed when o_valid && i_ready.
REQ-016 o_ready SHALL equal !o_valid || i_ready (single output register, full throughput, no combinational path from i_valid to o_valid).
REQ-017 SUB/ADD beats SHALL produce o on the cycle after acceptance (latency 1), with o_valid high until consumed.
REQ-018 The FSM SHALL have states IDLE and ACCUM; reset state IDLE.
REQ-019 In IDLE, an accepted ACC_* beat with i_last=0 SHALL load acc = 0 ± operands and move to ACCUM without asserting o_valid.
REQ-020 In ACCUM, each accepted ACC_* beat SHALL update acc; a beat with i_last=1 SHALL drive o = final acc, set o_valid, and return to IDLE.
REQ-021 An ACC_* beat with i_last=1 in IDLE SHALL be a one-beat sequence: o = a±b, latency 1.
REQ-022 A SUB/ADD beat accepted in ACCUM SHALL be processed normally with latency 1 and SHALL leave acc and the state unchanged.
REQ-023 All per-lane intermediate sums SHALL be computed at WIDTH+2 bits; overflow is defined as the exact result lying outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 o_ovf[k] SHALL be set if lane k overflowed on any step contributing to the emitted result (sticky across an accumulation sequence).
REQ-025 o and o_ovf SHALL be held stable while o_valid && !i_ready.

Reset
REQ-026 On rst_n low: o_valid=0, o=0, o_ovf=0, acc=0, sticky flags=0, state IDLE, regardless of any sequence in progress.
REQ-027 o_ready SHALL read 1 during and immediately after reset.

Configuration
REQ-028 Macro ADDSUB_PIPE_SAT_EN defined: each overflowing step SHALL clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1), and the clamped value SHALL feed the next accumulation step.
REQ-029 Macro not defined: results SHALL wrap modulo 2^WIDTH; o_ovf SHALL be reported identically.

Structure
REQ-030 Package addsub_pkg SHALL hold the mode encodings, the FSM state typedef and the saturation bounds as functions of WIDTH.
REQ-031 Per-lane arithmetic (three-operand add/sub, overflow detect, optional clamp) SHALL live in sub-module addsub_lane, instantiated LANES times by generate.

Verification (WIDTH=16, LANES=4)
REQ-032 ADD, a=100, b=-30 all lanes, i_ready=1 -> next cycle o_valid=1, o=70 per lane, o_ovf=0.
REQ-033 SUB, a=-32768, b=1 lane 0 -> SAT_EN: o=-32768, o_ovf[0]=1; no SAT_EN: o=32767, o_ovf[0]=1.
REQ-034 ACC_ADD beats (a,b)=(1,2),(3,4),(5,6,last) -> single o_valid after third beat, o=21, no intermediate o_valid.
REQ-035 Hold i_ready=0 with o_valid=1 for 5 cycles -> o stable, o_ready=0, next beat stalled; release -> beat accepted the same cycle.
REQ-036 Assert rst_n low mid-ACCUM after two beats -> o_valid=0, state IDLE; next ACC_ADD (10,0,last) -> o=10.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub pipeline: mode encodings, FSM state type
// and saturation bounds. Optional clamping is selected by ADDSUB_PIPE_SAT_EN.
package addsub_pkg;

    // Operation encodings on i_mode
    localparam logic [1:0] ModeSub    = 2'b00;
    localparam logic [1:0] ModeAdd    = 2'b01;
    localparam logic [1:0] ModeAccAdd = 2'b10;
    localparam logic [1:0] ModeAccSub = 2'b11;

    // Accumulation FSM
    typedef logic [0:0] state_t;
    localparam state_t StIdle  = 1'b0;
    localparam state_t StAccum = 1'b1;

    // Largest representable signed value at width w
    function automatic int sat_max(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    // Smallest representable signed value at width w
    function automatic int sat_min(input int w);
        return -(1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/addsub_lane.sv
// One lane of the add/sub pipeline: acc + a +/- b at WIDTH+2 bits, overflow
// detection, and wrap or clamp (clamp when ADDSUB_PIPE_SAT_EN is defined).
module addsub_lane
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             sub,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam int unsigned EW = WIDTH + 2;
    localparam logic signed [EW-1:0] MaxV = EW'(sat_max(WIDTH));
    localparam logic signed [EW-1:0] MinV = EW'(sat_min(WIDTH));

    logic signed [EW-1:0] ext_acc;
    logic signed [EW-1:0] ext_a;
    logic signed [EW-1:0] ext_b;
    logic signed [EW-1:0] sum;

    // Exact three-operand sum and out-of-range detection
    always_comb begin
        ext_acc = use_acc ? {{2{acc[WIDTH-1]}}, acc} : '0;
        ext_a   = {{2{a[WIDTH-1]}}, a};
        ext_b   = {{2{b[WIDTH-1]}}, b};
        sum     = sub ? (ext_acc + ext_a - ext_b) : (ext_acc + ext_a + ext_b);
        ovf     = (sum > MaxV) || (sum < MinV);
    end

    // Final lane value: clamp toward the overflow direction or wrap
    always_comb begin
`ifdef ADDSUB_PIPE_SAT_EN
        if (ovf) begin
            res = sum[EW-1] ? MinV[WIDTH-1:0] : MaxV[WIDTH-1:0];
        end else begin
            res = sum[WIDTH-1:0];
        end
`else
        res = sum[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/addsub_pipe.sv
// Multi-lane signed add/sub with optional accumulation sequences and a single
// registered output stage with valid/ready handshakes on both sides.
// Macro ADDSUB_PIPE_SAT_EN selects saturating arithmetic inside each lane.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*WIDTH-1:0] i_a,
    input  logic [LANES*WIDTH-1:0] i_b,
    input  logic [1:0]             i_mode,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANES*WIDTH-1:0] o,
    output logic [LANES-1:0]       o_ovf
);

    state_t                 state_q;
    logic [LANES*WIDTH-1:0] acc_q;
    logic [LANES-1:0]       sticky_q;
    logic [LANES*WIDTH-1:0] o_q;
    logic [LANES-1:0]       ovf_q;
    logic                   valid_q;

    logic                   accept;
    logic                   is_acc;
    logic                   sub;
    logic                   use_acc;
    logic [LANES*WIDTH-1:0] lane_res;
    logic [LANES-1:0]       lane_ovf;

    // Handshake and mode decode; only one output register, so ready depends on it alone
    always_comb begin
        o_ready = !valid_q || i_ready;
        accept  = i_valid && o_ready;
        is_acc  = (i_mode == ModeAccAdd) || (i_mode == ModeAccSub);
        sub     = (i_mode == ModeSub) || (i_mode == ModeAccSub);
        use_acc = is_acc && (state_q == StAccum);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        addsub_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .acc     (acc_q[k*WIDTH +: WIDTH]),
            .a       (i_a[k*WIDTH +: WIDTH]),
            .b       (i_b[k*WIDTH +: WIDTH]),
            .use_acc (use_acc),
            .sub     (sub),
            .res     (lane_res[k*WIDTH +: WIDTH]),
            .ovf     (lane_ovf[k])
        );
    end

    // Output register, accumulator and FSM update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            sticky_q <= '0;
            o_q      <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                if (!is_acc) begin
                    // Plain beat: acc and state untouched even mid-sequence
                    o_q     <= lane_res;
                    ovf_q   <= lane_ovf;
                    valid_q <= 1'b1;
                end else if (i_last) begin
                    o_q      <= lane_res;
                    ovf_q    <= lane_ovf | (use_acc ? sticky_q : '0);
                    valid_q  <= 1'b1;
                    acc_q    <= '0;
                    sticky_q <= '0;
                    state_q  <= StIdle;
                end else begin
                    acc_q    <= lane_res;
                    sticky_q <= lane_ovf | (use_acc ? sticky_q : '0);
                    state_q  <= StAccum;
                end
            end
        end
    end

    assign o_valid = valid_q;
    assign o       = o_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (WIDTH=16, LANES=4).
// Expected values follow ADDSUB_PIPE_SAT_EN when it is defined for the build.
module tb_addsub_pipe;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic [1:0]  i_mode;
    logic        i_last;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o;
    logic [3:0]  o_ovf;

    int checks = 0;
    int errors = 0;

    addsub_pipe #(
        .WIDTH (16),
        .LANES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_mode  (i_mode),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o       (o),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rep(input int v);
        logic [15:0] x;
        x = v[15:0];
        return {4{x}};
    endfunction

    function automatic logic [63:0] lanes(input int v0, input int v1, input int v2, input int v3);
        logic [15:0] x0, x1, x2, x3;
        x0 = v0[15:0];
        x1 = v1[15:0];
        x2 = v2[15:0];
        x3 = v3[15:0];
        return {x3, x2, x1, x0};
    endfunction

    // Present one beat for one clock edge, then drop i_valid 1 time unit after the edge
    task automatic beat(input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b,
                        input logic last);
        i_valid = 1'b1;
        i_mode  = mode;
        i_a     = a;
        i_b     = b;
        i_last  = last;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_mode  = 2'b00;
        i_last  = 1'b0;
        i_ready = 1'b1;
        #2;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_o", o, 64'd0);
        check("rst_ovf", 64'(o_ovf), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(o_ready), 64'd1);

        // ADD 100 + -30
        beat(2'b01, rep(100), rep(-30), 1'b0);
        check("add_valid", 64'(o_valid), 64'd1);
        check("add_o", o, rep(70));
        check("add_ovf", 64'(o_ovf), 64'd0);
        @(posedge clk);
        #1;
        check("add_consumed", 64'(o_valid), 64'd0);

        // SUB with overflow in lane 0 only
        beat(2'b00, lanes(-32768, 5, 5, 5), lanes(1, 2, 2, 2), 1'b0);
        check("sub_valid", 64'(o_valid), 64'd1);
`ifdef ADDSUB_PIPE_SAT_EN
        check("sub_ovf_o", o, lanes(-32768, 3, 3, 3));
`else
        check("sub_ovf_o", o, lanes(32767, 3, 3, 3));
`endif
        check("sub_ovf_flag", 64'(o_ovf), 64'b0001);

        // ACC_ADD three-beat sequence
        beat(2'b10, rep(1), rep(2), 1'b0);
        check("acc_b1_novalid", 64'(o_valid), 64'd0);
        beat(2'b10, rep(3), rep(4), 1'b0);
        check("acc_b2_novalid", 64'(o_valid), 64'd0);
        beat(2'b10, rep(5), rep(6), 1'b1);
        check("acc_valid", 64'(o_valid), 64'd1);
        check("acc_o", o, rep(21));
        check("acc_ovf", 64'(o_ovf), 64'd0);

        // Sticky overflow: first step overflows lane 0, second does not
        beat(2'b10, lanes(32767, 1, 1, 1), lanes(1, 1, 1, 1), 1'b0);
        check("sticky_b1_novalid", 64'(o_valid), 64'd0);
        beat(2'b10, rep(0), rep(0), 1'b1);
`ifdef ADDSUB_PIPE_SAT_EN
        check("sticky_o", o, lanes(32767, 2, 2, 2));
`else
        check("sticky_o", o, lanes(-32768, 2, 2, 2));
`endif
        check("sticky_ovf", 64'(o_ovf), 64'b0001);

        // One-beat ACC_SUB from IDLE
        beat(2'b11, rep(10), rep(3), 1'b1);
        check("onebeat_valid", 64'(o_valid), 64'd1);
        check("onebeat_o", o, rep(7));

        // Plain ADD inside an accumulation leaves acc alone
        beat(2'b10, rep(10), rep(0), 1'b0);
        check("mid_b1_novalid", 64'(o_valid), 64'd0);
        beat(2'b01, rep(1), rep(1), 1'b0);
        check("mid_add_valid", 64'(o_valid), 64'd1);
        check("mid_add_o", o, rep(2));
        beat(2'b11, rep(0), rep(-5), 1'b1);
        check("mid_final_o", o, rep(15));

        // Backpressure: hold result for 5 cycles while a new beat waits
        beat(2'b01, rep(7), rep(8), 1'b0);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_mode  = 2'b01;
        i_a     = rep(1);
        i_b     = rep(1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_o", o, rep(15));
            check("stall_valid", 64'(o_valid), 64'd1);
            check("stall_ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        #1;
        check("release_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("release_valid", 64'(o_valid), 64'd1);
        check("release_o", o, rep(2));

        // Reset in the middle of an accumulation with a result pending
        beat(2'b10, rep(1), rep(1), 1'b0);
        beat(2'b10, rep(2), rep(2), 1'b0);
        beat(2'b01, rep(3), rep(3), 1'b0);
        i_ready = 1'b0;
        #3;
        check("pre_rst_valid", 64'(o_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(o_valid), 64'd0);
        check("mid_rst_o", o, 64'd0);
        check("mid_rst_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        beat(2'b10, rep(10), rep(0), 1'b1);
        check("after_rst_valid", 64'(o_valid), 64'd1);
        check("after_rst_o", o, rep(10));
        check("after_rst_ovf", 64'(o_ovf), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
